cbfp_denorm: RTL and testbench

Inverse of the CBFP stage-0 normaliser. Takes 16-lane batches of 11-bit complex mantissas, each with a 5-bit per-element shift index. Restores each element to the common 23-bit fixed-point scale, and reports the minimum index seen per 64-point block. Sits at the FFT output, after the last butterfly stage, ahead of any reorder or output buffer.

---
 rtl/cbfp_pkg.sv | 27 ++
 rtl/cbfp_denorm_lane.sv | 29 ++
 rtl/cbfp_denorm.sv | 107 ++++++++++
 tb/tb_cbfp_denorm.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// Shared CBFP constants and complex sample types (normaliser and denormaliser).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cbfp_pkg;

  localparam int BW_IN           = 11;
  localparam int BW_OUT          = 23;
  localparam int IDX_W           = 5;
  localparam int BATCH_SIZE      = 16;
  localparam int BLOCK_SIZE      = 64;

  // Mantissas sit this many bits below the restored fixed-point scale.
  localparam int SHIFT_BASE      = BW_OUT - BW_IN;
  localparam int BEATS_PER_BLOCK = BLOCK_SIZE / BATCH_SIZE;
  localparam int BEAT_CNT_W      = $clog2(BEATS_PER_BLOCK);

  typedef struct packed {
    logic signed [BW_IN-1:0] re;
    logic signed [BW_IN-1:0] im;
  } cplx_mant_t;

  typedef struct packed {
    logic signed [BW_OUT-1:0] re;
    logic signed [BW_OUT-1:0] im;
  } cplx_out_t;

endpackage

// File: rtl/cbfp_denorm_lane.sv
// One complex lane: restores a mantissa pair to the common fixed-point scale.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; evaluates whatever is presented.
module cbfp_denorm_lane
  import cbfp_pkg::*;
(
  input  cplx_mant_t       mant,
  input  logic [IDX_W-1:0] idx,
  output cplx_out_t        res
);

  // Place the mantissa at the top of the output word (exact, no overflow
  // possible), then arithmetic-shift right by the index. Indices beyond the
  // word width collapse to the sign, i.e. floor toward minus infinity.
  function automatic logic signed [BW_OUT-1:0] restore(
    input logic signed [BW_IN-1:0] m,
    input logic [IDX_W-1:0]        sh
  );
    logic signed [BW_OUT-1:0] base;
    base = {m, {SHIFT_BASE{1'b0}}};
    if (int'(sh) >= BW_OUT)
      return {BW_OUT{m[BW_IN-1]}};
    return base >>> sh;
  endfunction

  assign res.re = restore(mant.re, idx);
  assign res.im = restore(mant.im, idx);

endmodule

// File: rtl/cbfp_denorm.sv
// CBFP denormaliser: per-element shift restore of 16 lanes plus per-block min index.
// Latency: 2 cycles in_valid -> valid_out, one beat per cycle.
// Backpressure: none; gaps in in_valid propagate unchanged to valid_out.
module cbfp_denorm
  import cbfp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [BW_IN-1:0]  real_in   [0:BATCH_SIZE-1],
  input  logic signed [BW_IN-1:0]  imag_in   [0:BATCH_SIZE-1],
  input  logic [IDX_W-1:0]         index_in  [0:BATCH_SIZE-1],
  output logic signed [BW_OUT-1:0] real_out  [0:BATCH_SIZE-1],
  output logic signed [BW_OUT-1:0] imag_out  [0:BATCH_SIZE-1],
  output logic                     valid_out,
  output logic                     last_out,
  output logic [IDX_W-1:0]         blk_min_idx
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_BLOCK - 1);

  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [IDX_W-1:0]      trk_min;
  logic [IDX_W-1:0]      beat_min;

  cplx_mant_t            s1_mant [BATCH_SIZE];
  logic [IDX_W-1:0]      s1_idx  [BATCH_SIZE];
  logic                  s1_vld;
  logic                  s1_last;
  cplx_out_t             lane_res [BATCH_SIZE];

  // Minimum index across the lanes of the incoming beat.
  always_comb begin
    beat_min = index_in[0];
    for (int i = 1; i < BATCH_SIZE; i++)
      if (index_in[i] < beat_min) beat_min = index_in[i];
  end

  // Beat counter and running block minimum; beat 0 reloads so adjacent blocks
  // never mix, while S2 commits the previous block's value from the old trk_min.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      trk_min  <= '1;
    end else if (in_valid) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (beat_cnt == '0 || beat_min < trk_min)
        trk_min <= beat_min;
    end
  end

  // S1: capture the beat, its indices and whether it closes a block.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      for (int i = 0; i < BATCH_SIZE; i++) begin
        s1_mant[i] <= '0;
        s1_idx[i]  <= '0;
      end
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_last <= (beat_cnt == LAST_BEAT);
        for (int i = 0; i < BATCH_SIZE; i++) begin
          s1_mant[i] <= '{re: real_in[i], im: imag_in[i]};
          s1_idx[i]  <= index_in[i];
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < BATCH_SIZE; g++) begin : g_lane
      cbfp_denorm_lane u_lane (
        .mant (s1_mant[g]),
        .idx  (s1_idx[g]),
        .res  (lane_res[g])
      );
    end
  endgenerate

  // S2: register restored samples; outputs hold while no beat is present.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
      blk_min_idx <= '0;
      for (int i = 0; i < BATCH_SIZE; i++) begin
        real_out[i] <= '0;
        imag_out[i] <= '0;
      end
    end else begin
      valid_out <= s1_vld;
      if (s1_vld) begin
        last_out <= s1_last;
        if (s1_last) blk_min_idx <= trk_min;
        for (int i = 0; i < BATCH_SIZE; i++) begin
          real_out[i] <= lane_res[i].re;
          imag_out[i] <= lane_res[i].im;
        end
      end
    end
  end

endmodule

// File: tb/tb_cbfp_denorm.sv
// Scoreboard bench for cbfp_denorm: driver pushes expected beats, monitor pops on valid_out.
// Latency: expects outputs 2 cycles after each issued beat.
// Backpressure: none; driver inserts random idle gaps.
module tb_cbfp_denorm;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [10:0] real_in   [0:15];
  logic signed [10:0] imag_in   [0:15];
  logic [4:0]         index_in  [0:15];
  logic signed [22:0] real_out  [0:15];
  logic signed [22:0] imag_out  [0:15];
  logic               valid_out;
  logic               last_out;
  logic [4:0]         blk_min_idx;

  cbfp_denorm dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .real_in     (real_in),
    .imag_in     (imag_in),
    .index_in    (index_in),
    .real_out    (real_out),
    .imag_out    (imag_out),
    .valid_out   (valid_out),
    .last_out    (last_out),
    .blk_min_idx (blk_min_idx)
  );

  typedef struct {
    int     cyc;
    longint re [16];
    longint im [16];
    bit     last;
    int     bmin;
  } exp_t;

  exp_t   sb_q [$];
  int     blk_idx_q [$];
  int     committed_min;
  int     cyc;
  int     n_checks;
  int     n_fail;

  int     st_re  [16];
  int     st_im  [16];
  int     st_idx [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int lane, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s lane %0d: got %0d expected %0d (cycle %0d)", name, lane, act, expv, cyc);
    end
  endtask

  // Floor of m * 2^12 / 2^idx, computed with plain integer division.
  function automatic longint ref_restore(input int m, input int idx);
    longint v;
    longint d;
    v = longint'(m) * 4096;
    d = longint'(1) << idx;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  // Drive one beat from st_* and push its expected output.
  task automatic issue_beat();
    exp_t e;
    int   mn;
    for (int i = 0; i < 16; i++) begin
      real_in[i]  = 11'(st_re[i]);
      imag_in[i]  = 11'(st_im[i]);
      index_in[i] = 5'(st_idx[i]);
      e.re[i] = ref_restore(st_re[i], st_idx[i]);
      e.im[i] = ref_restore(st_im[i], st_idx[i]);
      blk_idx_q.push_back(st_idx[i]);
    end
    e.last = 1'b0;
    if (blk_idx_q.size() == 64) begin
      mn = 31;
      foreach (blk_idx_q[k]) if (blk_idx_q[k] < mn) mn = blk_idx_q[k];
      blk_idx_q.delete();
      committed_min = mn;
      e.last = 1'b1;
    end
    e.bmin = committed_min;
    e.cyc  = cyc + 2;
    sb_q.push_back(e);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_mant();
    for (int i = 0; i < 16; i++) begin
      st_re[i] = int'($signed(11'($urandom)));
      st_im[i] = int'($signed(11'($urandom)));
    end
  endtask

  task automatic set_idx(input int v);
    for (int i = 0; i < 16; i++) st_idx[i] = v;
  endtask

  // Monitor: every valid output beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (valid_out) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid_out", -1, 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_cycle", -1, cyc, e.cyc);
        chk("last_out", -1, last_out, e.last);
        chk("blk_min_idx", -1, blk_min_idx, e.bmin);
        for (int i = 0; i < 16; i++) begin
          chk("real_out", i, real_out[i], e.re[i]);
          chk("imag_out", i, imag_out[i], e.im[i]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    committed_min = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      real_in[i] = '0;
      imag_in[i] = '0;
      index_in[i] = '0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_valid_out", -1, valid_out, 0);
    chk("rst_last_out", -1, last_out, 0);
    chk("rst_blk_min", -1, blk_min_idx, 0);
    chk("rst_real_out", 0, real_out[0], 0);
    chk("rst_imag_out", 15, imag_out[15], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Lane arithmetic corner cases (lanes 0..4, real and imag equal), 4 beats.
    for (int b = 0; b < 4; b++) begin
      rand_mant();
      for (int i = 0; i < 16; i++) st_idx[i] = $urandom_range(0, 31);
      st_re[0] = 1;     st_idx[0] = 0;
      st_re[1] = -1024; st_idx[1] = 12;
      st_re[2] = 1023;  st_idx[2] = 1;
      st_re[3] = 5;     st_idx[3] = 31;
      st_re[4] = -5;    st_idx[4] = 31;
      for (int i = 0; i < 5; i++) st_im[i] = st_re[i];
      if (b == 0) begin
        // Hand-derived expectations pin the reference model itself.
        chk("ref_m1_i0", 0, ref_restore(st_re[0], st_idx[0]), 4096);
        chk("ref_m-1024_i12", 1, ref_restore(st_re[1], st_idx[1]), -1024);
        chk("ref_m1023_i1", 2, ref_restore(st_re[2], st_idx[2]), 2095104);
        chk("ref_m5_i31", 3, ref_restore(st_re[3], st_idx[3]), 0);
        chk("ref_m-5_i31", 4, ref_restore(st_re[4], st_idx[4]), -1);
      end
      issue_beat();
    end
    idle(3);

    // Block framing: idx = lane number on four consecutive beats.
    for (int b = 0; b < 4; b++) begin
      rand_mant();
      for (int i = 0; i < 16; i++) st_idx[i] = i;
      issue_beat();
    end
    idle(3);

    // Gapped block: 0/2/1 idle cycles, beat 2 all idx 3, others idx 7.
    for (int b = 0; b < 4; b++) begin
      rand_mant();
      set_idx(b == 2 ? 3 : 7);
      issue_beat();
      if (b == 1) idle(2);
      if (b == 2) idle(1);
    end
    idle(3);

    // Back-to-back blocks: A all idx 9, B all idx 4.
    for (int b = 0; b < 8; b++) begin
      rand_mant();
      set_idx(b < 4 ? 9 : 4);
      issue_beat();
    end
    idle(3);

    // Reset mid-block: two beats, one reset cycle carrying a dropped beat.
    for (int b = 0; b < 2; b++) begin
      rand_mant();
      set_idx(1);
      issue_beat();
    end
    rst = 1'b1;
    in_valid = 1'b1;
    while (sb_q.size() > 0 && sb_q[sb_q.size()-1].cyc > cyc) void'(sb_q.pop_back());
    blk_idx_q.delete();
    committed_min = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    idle(1);
    for (int b = 0; b < 4; b++) begin
      rand_mant();
      set_idx(6);
      issue_beat();
    end
    idle(3);

    // Random sweep with random gaps.
    for (int n = 0; n < 1000; n++) begin
      rand_mant();
      for (int i = 0; i < 16; i++)
        st_idx[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(8, 31);
      issue_beat();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(5);

    chk("scoreboard_drained", -1, sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
